// File: rtl/fft_pad_pkg.sv
// Shared sizing helpers, FIFO entry layout and serializer states for the FFT pad serializer.
package fft_pad_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } pad_state_e;

  // Entry = {word, sof, ovf}; the flags sit in the two LSBs.
  localparam int ENT_OVF_BIT = 0;
  localparam int ENT_SOF_BIT = 1;
  localparam int ENT_FLAG_W  = 2;

  function automatic int calc_w(input int aw, input int dw);
    return aw + 2 * dw;
  endfunction

  function automatic int calc_beats(input int w, input int pw);
    return (w + pw - 1) / pw;
  endfunction

endpackage

// File: rtl/fft_pad_fifo.sv
// Synchronous FIFO; a push while full is accepted when a pop happens in the same cycle.
module fft_pad_fifo #(
  parameter int WIDTH = 46,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW2 = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW2:0]     wr_ptr_q, wr_ptr_d;
  logic [PW2:0]     rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty.
  always_comb begin
    empty_o   = (wr_ptr_q == rd_ptr_q);
    full_o    = (wr_ptr_q[PW2] != rd_ptr_q[PW2]) &&
                (wr_ptr_q[PW2-1:0] == rd_ptr_q[PW2-1:0]);
    do_pop    = pop_i & ~empty_o;
    do_push   = push_i & (~full_o | do_pop);
    wr_ptr_d  = wr_ptr_q + (do_push ? {{PW2{1'b0}}, 1'b1} : '0);
    rd_ptr_d  = rd_ptr_q + (do_pop ? {{PW2{1'b0}}, 1'b1} : '0);
    rd_data_o = mem_q[rd_ptr_q[PW2-1:0]];
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PW2-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/fft_pad_serializer.sv
// Buffers FFT result samples and emits them MSB-first over a narrow pad bus.
module fft_pad_serializer
  import fft_pad_pkg::*;
#(
  parameter int DW    = 19,
  parameter int AW    = 6,
  parameter int PW    = 8,
  parameter int DEPTH = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ED,
  input  logic          RDY,
  input  logic [AW-1:0] ADDR,
  input  logic [DW-1:0] DOR,
  input  logic [DW-1:0] DOI,
  input  logic          OVF1,
  input  logic          OVF2,
  input  logic          PAD_HOLD,
  output logic [PW-1:0] PAD_D,
  output logic          PAD_VLD,
  output logic          PAD_SOF,
  output logic          PAD_LAST,
  output logic          PAD_OVF,
  output logic          DROP,
  output logic          SYNC_ERR
);

  localparam int WW    = calc_w(AW, DW);
  localparam int BEATS = calc_beats(WW, PW);
  localparam int SW    = BEATS * PW;
  localparam int EW    = WW + ENT_FLAG_W;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic          in_frame_q, in_frame_d;
  logic [AW-1:0] smp_cnt_q, smp_cnt_d;
  logic          drop_q, drop_d, sync_q, sync_d;
  logic          cap, full, empty, pop_now, load;
  logic [EW-1:0] head, ent;

  pad_state_e    state_q, state_d;
  logic [SW-1:0] shift_q, shift_d;
  logic [BCW-1:0] beat_q, beat_d;
  logic          sof_q, sof_d, ovf_q, ovf_d;

  logic [PW-1:0] pad_d_q;
  logic          pad_vld_q, pad_sof_q, pad_last_q, pad_ovf_q;

  assign ent = {ADDR, DOR, DOI, RDY, OVF1 | OVF2};

  fft_pad_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk_i    (CLK),
    .rst_i    (RST),
    .push_i   (cap),
    .wr_data_i(ent),
    .pop_i    (pop_now),
    .rd_data_o(head),
    .full_o   (full),
    .empty_o  (empty)
  );

  // Frame tracker and sticky error flags.
  always_comb begin
    cap        = ED & (RDY | in_frame_q);
    in_frame_d = in_frame_q;
    smp_cnt_d  = smp_cnt_q;
    if (cap) begin
      if (RDY) begin
        in_frame_d = 1'b1;
        smp_cnt_d  = AW'(1);
      end else begin
        smp_cnt_d = smp_cnt_q + AW'(1);
        if (smp_cnt_q == '1) in_frame_d = 1'b0;
      end
    end
    drop_d = drop_q | (cap & full & ~pop_now);
    sync_d = sync_q | (ED & RDY & in_frame_q);
  end

  // Serializer next state; last beat reloads directly for back-to-back samples.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    beat_d  = beat_q;
    sof_d   = sof_q;
    ovf_d   = ovf_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: load = ~empty;
      ST_SEND: begin
        if (!PAD_HOLD) begin
          if (beat_q == BCW'(BEATS - 1)) begin
            if (!empty) load = 1'b1;
            else        state_d = ST_IDLE;
          end else begin
            shift_d = shift_q << PW;
            beat_d  = beat_q + BCW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pop_now = load;
    if (load) begin
      state_d = ST_SEND;
      shift_d = SW'(head[EW-1:ENT_FLAG_W]);
      beat_d  = '0;
      sof_d   = head[ENT_SOF_BIT];
      ovf_d   = head[ENT_OVF_BIT];
    end
  end

  // State registers; pad outputs are registered from next-state values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      in_frame_q <= 1'b0;
      smp_cnt_q  <= '0;
      drop_q     <= 1'b0;
      sync_q     <= 1'b0;
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      beat_q     <= '0;
      sof_q      <= 1'b0;
      ovf_q      <= 1'b0;
      pad_d_q    <= '0;
      pad_vld_q  <= 1'b0;
      pad_sof_q  <= 1'b0;
      pad_last_q <= 1'b0;
      pad_ovf_q  <= 1'b0;
    end else begin
      in_frame_q <= in_frame_d;
      smp_cnt_q  <= smp_cnt_d;
      drop_q     <= drop_d;
      sync_q     <= sync_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      beat_q     <= beat_d;
      sof_q      <= sof_d;
      ovf_q      <= ovf_d;
      pad_vld_q  <= (state_d == ST_SEND);
      pad_d_q    <= (state_d == ST_SEND) ? shift_d[SW-1 -: PW] : '0;
      pad_sof_q  <= (state_d == ST_SEND) && (beat_d == '0) && sof_d;
      pad_ovf_q  <= (state_d == ST_SEND) && (beat_d == '0) && ovf_d;
      pad_last_q <= (state_d == ST_SEND) && (beat_d == BCW'(BEATS - 1));
    end
  end

  assign PAD_D    = pad_d_q;
  assign PAD_VLD  = pad_vld_q;
  assign PAD_SOF  = pad_sof_q;
  assign PAD_LAST = pad_last_q;
  assign PAD_OVF  = pad_ovf_q;
  assign DROP     = drop_q;
  assign SYNC_ERR = sync_q;

endmodule
